// File: rtl/ccw_chain_sequencer.sv
// ccw_chain_sequencer
//   Channel-program controller. Fetches 64-bit CCWs over an AXI4-Lite-style
//   read master, hands each one to the channel engine, and follows command
//   chaining, TIC and status-modifier skip. It ends with a CSW-style result.
// Ports:
//   clk, reset            clock, async active-high reset
//   start/stop/caw_addr   program control (start pulse, stop level, first CCW)
//   busy/done/result      program status; done pulses once with result valid
//   csw_*                 last CCW address + 8, last device status, residual
//   m_axi_ar*/m_axi_r*    CCW fetch read channel
//   ch_*                  channel engine command/handshake/status
module ccw_chain_sequencer #(
  parameter int START_TIMEOUT = 1024,  // must be >= 2
  parameter int MAX_CHAIN     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] caw_addr,
  output logic        busy,
  output logic        done,
  output logic [2:0]  result,
  output logic [31:0] csw_ccw_addr,
  output logic [7:0]  csw_status,
  output logic [15:0] csw_count,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [63:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [7:0]  ch_command,
  output logic [15:0] ch_count,
  output logic [31:0] ch_data_addr,
  output logic        ch_start,
  output logic        ch_stop,
  input  logic        ch_active,
  input  logic [7:0]  ch_status_tdata,
  input  logic        ch_status_tvalid,
  input  logic [15:0] ch_residual
);

  typedef enum logic [3:0] {
    IDLE, FETCH_AR, FETCH_R, DECODE, START, WAIT_ACTIVE, RUN, STOPPING, FINISH
  } state_t;

  localparam logic [2:0] RES_OK   = 3'd0;
  localparam logic [2:0] RES_UNIT = 3'd1;
  localparam logic [2:0] RES_PROG = 3'd2;
  localparam logic [2:0] RES_AXI  = 3'd3;
  localparam logic [2:0] RES_TMO  = 3'd4;
  localparam logic [2:0] RES_STOP = 3'd5;

  // The counter is cleared in START and counts WAIT_ACTIVE cycles from 0, so
  // leaving at START_TIMEOUT-2 places the done pulse START_TIMEOUT cycles
  // after the ch_start pulse.
  localparam logic [31:0] TMO_LAST = 32'(START_TIMEOUT - 2);

  state_t      state, state_n;
  logic [31:0] ptr, tmo_cnt;
  logic [7:0]  chain_cnt, ccw_cmd;
  logic [23:0] ccw_daddr;
  logic [15:0] ccw_cnt;
  logic        ccw_cd, ccw_cc, tic_flag, stop_pend;
  logic [2:0]  res_n;
  logic [7:0]  eff_status;
  logic        status_bad, is_tic, fetch_stop;
  logic        unused_bits;

  // A status byte arriving in the same cycle as the channel going idle still
  // counts for the completion decision.
  assign eff_status = ch_status_tvalid ? ch_status_tdata : csw_status;
  assign status_bad = eff_status[1] | eff_status[0] | ~(eff_status[3] & eff_status[2]);
  assign is_tic     = (ccw_cmd[3:0] == 4'h8);
  assign fetch_stop = stop | stop_pend;
  assign unused_bits = ^{m_axi_rdata[29:16], eff_status[7], eff_status[5:4]};

  assign busy          = (state != IDLE) && (state != FINISH);
  assign done          = (state == FINISH);
  assign m_axi_araddr  = ptr;
  assign m_axi_arvalid = (state == FETCH_AR);
  assign m_axi_rready  = (state == FETCH_R);
  assign ch_start      = (state == START);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    res_n   = result;
    ch_stop = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (caw_addr[2:0] != 3'd0) begin
          state_n = FINISH;
          res_n   = RES_PROG;
        end else begin
          state_n = FETCH_AR;
        end
      end
      FETCH_AR: if (m_axi_arready) state_n = FETCH_R;
      FETCH_R: if (m_axi_rvalid) begin
        state_n = FINISH;
        if (fetch_stop)                res_n = RES_STOP;
        else if (m_axi_rresp != 2'b00) res_n = RES_AXI;
        else                           state_n = DECODE;
      end
      DECODE: begin
        if (is_tic) begin
          if (tic_flag || ccw_daddr[2:0] != 3'd0) begin
            state_n = FINISH;
            res_n   = RES_PROG;
          end else begin
            state_n = FETCH_AR;
          end
        end else if (ccw_cd || ccw_cnt == 16'd0 || chain_cnt == 8'(MAX_CHAIN)) begin
          state_n = FINISH;
          res_n   = RES_PROG;
        end else begin
          state_n = START;
        end
      end
      START: begin
        if (stop) begin
          ch_stop = 1'b1;
          state_n = STOPPING;
        end else begin
          state_n = WAIT_ACTIVE;
        end
      end
      WAIT_ACTIVE: begin
        if (stop) begin
          ch_stop = 1'b1;
          state_n = STOPPING;
        end else if (ch_active) begin
          state_n = RUN;
        end else if (ch_status_tvalid && ch_status_tdata[1]) begin
          state_n = FINISH;
          res_n   = RES_UNIT;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n = FINISH;
          res_n   = RES_TMO;
        end
      end
      RUN: begin
        // stop beats a chain decision taken in the same cycle
        if (stop) begin
          ch_stop = 1'b1;
          state_n = STOPPING;
        end else if (!ch_active) begin
          if (status_bad) begin
            state_n = FINISH;
            res_n   = RES_UNIT;
          end else if (!ccw_cc) begin
            state_n = FINISH;
            res_n   = RES_OK;
          end else begin
            state_n = FETCH_AR;
          end
        end
      end
      STOPPING: if (!ch_active) begin
        state_n = FINISH;
        res_n   = RES_STOP;
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr          <= '0;
      tmo_cnt      <= '0;
      chain_cnt    <= '0;
      tic_flag     <= 1'b0;
      stop_pend    <= 1'b0;
      ccw_cmd      <= '0;
      ccw_daddr    <= '0;
      ccw_cnt      <= '0;
      ccw_cd       <= 1'b0;
      ccw_cc       <= 1'b0;
      result       <= '0;
      csw_ccw_addr <= '0;
      csw_status   <= '0;
      csw_count    <= '0;
      ch_command   <= '0;
      ch_count     <= '0;
      ch_data_addr <= '0;
    end else begin
      if (state_n == FINISH) result <= res_n;

      // status wins over the START clear when both land together
      if (ch_status_tvalid)    csw_status <= ch_status_tdata;
      else if (state == START) csw_status <= '0;

      case (state)
        IDLE: if (start) begin
          ptr       <= caw_addr;
          chain_cnt <= '0;
          tic_flag  <= 1'b0;
          stop_pend <= 1'b0;
        end
        FETCH_AR: if (stop) stop_pend <= 1'b1;
        FETCH_R: begin
          if (stop) stop_pend <= 1'b1;
          // a beat that completes after a stop is drained but not used
          if (m_axi_rvalid && !fetch_stop) begin
            ccw_cmd      <= m_axi_rdata[63:56];
            ccw_daddr    <= m_axi_rdata[55:32];
            ccw_cd       <= m_axi_rdata[31];
            ccw_cc       <= m_axi_rdata[30];
            ccw_cnt      <= m_axi_rdata[15:0];
            csw_ccw_addr <= ptr + 32'd8;
          end
        end
        DECODE: begin
          if (state_n == FETCH_AR) begin
            ptr      <= {8'h00, ccw_daddr};
            tic_flag <= 1'b1;
          end
          if (state_n == START) begin
            ch_command   <= ccw_cmd;
            ch_count     <= ccw_cnt;
            ch_data_addr <= {8'h00, ccw_daddr};
            chain_cnt    <= chain_cnt + 8'd1;
            tic_flag     <= 1'b0;
          end
        end
        START:       tmo_cnt <= '0;
        WAIT_ACTIVE: tmo_cnt <= tmo_cnt + 32'd1;
        RUN: if (!ch_active) begin
          csw_count <= ch_residual;
          // status modifier skips the next CCW
          if (state_n == FETCH_AR) ptr <= ptr + (eff_status[6] ? 32'd16 : 32'd8);
        end
        STOPPING: if (!ch_active) csw_count <= ch_residual;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ccw_chain_sequencer.sv
// Self-checking bench for ccw_chain_sequencer: memory-backed AXI read slave,
// a behavioural channel engine, and a scoreboard of expected fetches,
// channel starts and completions.
module tb_ccw_chain_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0;
  logic [31:0] caw_addr = '0;
  logic        busy, done;
  logic [2:0]  result;
  logic [31:0] csw_ccw_addr;
  logic [7:0]  csw_status;
  logic [15:0] csw_count;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid, m_axi_rready;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [63:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic [7:0]  ch_command;
  logic [15:0] ch_count;
  logic [31:0] ch_data_addr;
  logic        ch_start, ch_stop;
  logic        ch_active = 1'b0, ch_status_tvalid = 1'b0;
  logic [7:0]  ch_status_tdata = '0;
  logic [15:0] ch_residual = '0;

  ccw_chain_sequencer #(.START_TIMEOUT(16), .MAX_CHAIN(255)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .caw_addr(caw_addr),
    .busy(busy), .done(done), .result(result), .csw_ccw_addr(csw_ccw_addr),
    .csw_status(csw_status), .csw_count(csw_count),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready), .ch_command(ch_command), .ch_count(ch_count),
    .ch_data_addr(ch_data_addr), .ch_start(ch_start), .ch_stop(ch_stop), .ch_active(ch_active),
    .ch_status_tdata(ch_status_tdata), .ch_status_tvalid(ch_status_tvalid), .ch_residual(ch_residual)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  res;
    logic [31:0] addr;
    logic [7:0]  st;
    logic [15:0] cnt;
    bit          full;
  } exp_t;

  int total = 0, bad = 0, cyc = 0, done_n = 0, chstop_n = 0, chs_cyc = 0, done_cyc = 0;
  exp_t        exp_done[$];
  logic [31:0] exp_fetch[$];
  logic [55:0] exp_chs[$];   // {command, count, data_addr}
  logic [63:0] mem [logic [31:0]];
  logic [31:0] err_addr = 32'hFFFF_FFF8;
  int          r_delay = 0;
  int          ch_len = 10;
  logic [7:0]  ch_stat = 8'h0C;
  logic [15:0] ch_resid = '0;
  bit          ch_never = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [63:0] mk(input logic [7:0] cmd, input logic [23:0] a,
                                     input logic cd, input logic cc, input logic [15:0] n);
    return {cmd, a, cd, cc, 14'h0, n};
  endfunction

  // AXI read slave: decide at negedge, drive just after the next posedge
  initial begin : axi_slave
    bit ar_hs, r_hs, pend;
    logic [31:0] a, pa;
    int w;
    pend = 1'b0; w = 0; pa = '0;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      a     = m_axi_araddr;
      @(posedge clk); #1;
      m_axi_arready = (cyc % 3) != 1;
      if (reset) begin
        m_axi_rvalid = 1'b0;
        pend = 1'b0;
      end else begin
        if (r_hs) m_axi_rvalid = 1'b0;
        if (ar_hs) begin pend = 1'b1; pa = a; w = r_delay; end
        if (pend && !m_axi_rvalid) begin
          if (w == 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = mem.exists(pa) ? mem[pa] : 64'h0;
            m_axi_rresp  = (pa == err_addr) ? 2'b10 : 2'b00;
            pend = 1'b0;
          end else begin
            w--;
          end
        end
      end
    end
  end

  // Channel engine: active ch_len cycles, status one cycle before going idle
  initial begin : chan
    bit seen;
    forever begin
      @(negedge clk);
      if (ch_start && !reset && !ch_never) begin
        seen = 1'b0;
        @(posedge clk); #1;
        ch_active = 1'b1;
        for (int i = 0; i < ch_len; i++) begin
          @(negedge clk);
          if (ch_stop) seen = 1'b1;
          @(posedge clk); #1;
          ch_status_tvalid = (i == ch_len - 2);
          ch_status_tdata  = ch_stat;
          if (seen) break;
        end
        ch_status_tvalid = 1'b0;
        ch_active   = 1'b0;
        ch_residual = ch_resid;
      end
    end
  end

  // Scoreboard monitor
  initial begin : mon
    bit prev_arwait;
    exp_t d;
    logic [31:0] fa;
    logic [55:0] cs;
    prev_arwait = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (prev_arwait) begin
          total++;
          if (!m_axi_arvalid) begin bad++; $display("FAIL arvalid_hold: got 0 want 1"); end
        end
        if (m_axi_arvalid && m_axi_arready) begin
          total++;
          if (exp_fetch.size() == 0) begin
            bad++; $display("FAIL fetch_addr: got %h want none", m_axi_araddr);
          end else begin
            fa = exp_fetch.pop_front();
            if (m_axi_araddr !== fa) begin bad++; $display("FAIL fetch_addr: got %h want %h", m_axi_araddr, fa); end
          end
        end
        if (ch_start) begin
          chs_cyc = cyc;
          total++;
          if (exp_chs.size() == 0) begin
            bad++; $display("FAIL ch_start: got cmd %h want none", ch_command);
          end else begin
            cs = exp_chs.pop_front();
            if ({ch_command, ch_count, ch_data_addr} !== cs)
              begin bad++; $display("FAIL ch_start: got %h want %h", {ch_command, ch_count, ch_data_addr}, cs); end
          end
        end
        if (ch_stop) chstop_n++;
        if (done) begin
          done_n++;
          done_cyc = cyc;
          total++;
          if (busy !== 1'b0) begin bad++; $display("FAIL done_busy: got %b want 0", busy); end
          if (exp_done.size() == 0) begin
            bad++; $display("FAIL done: got result %0d want no done", result);
          end else begin
            d = exp_done.pop_front();
            total++;
            if (result !== d.res) begin bad++; $display("FAIL done_result: got %0d want %0d", result, d.res); end
            total++;
            if (csw_ccw_addr !== d.addr) begin bad++; $display("FAIL done_ccw_addr: got %h want %h", csw_ccw_addr, d.addr); end
            if (d.full) begin
              total++;
              if (csw_status !== d.st) begin bad++; $display("FAIL done_status: got %h want %h", csw_status, d.st); end
              total++;
              if (csw_count !== d.cnt) begin bad++; $display("FAIL done_count: got %h want %h", csw_count, d.cnt); end
            end
          end
        end
      end
      prev_arwait = !reset && m_axi_arvalid && !m_axi_arready;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_done(input logic [2:0] r, input logic [31:0] a, input logic [7:0] s,
                           input logic [15:0] c, input bit full);
    exp_t e;
    e.res = r; e.addr = a; e.st = s; e.cnt = c; e.full = full;
    exp_done.push_back(e);
  endtask

  task automatic run_prog(input logic [31:0] caw);
    caw_addr = caw;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n0, k;
    n0 = done_n; k = 0;
    while (done_n == n0 && k < budget) begin tick(1); k++; end
    total++;
    if (done_n == n0) begin bad++; $display("FAIL %s_wait: got no done want done within %0d cycles", nm, budget); end
  endtask

  task automatic wait_active(input string nm);
    int k;
    k = 0;
    while (!ch_active && k < 50) begin tick(1); k++; end
    total++;
    if (!ch_active) begin bad++; $display("FAIL %s_active: got 0 want 1", nm); end
  endtask

  task automatic check_empty(input string nm);
    total++;
    if (exp_fetch.size() != 0 || exp_chs.size() != 0 || exp_done.size() != 0) begin
      bad++;
      $display("FAIL %s_leftover: got fetch=%0d chs=%0d done=%0d want 0", nm,
               exp_fetch.size(), exp_chs.size(), exp_done.size());
    end
    exp_fetch.delete(); exp_chs.delete(); exp_done.delete();
    mem.delete();
  endtask

  task automatic test_reset;
    tick(3);
    total++;
    if ({busy, done, m_axi_arvalid, m_axi_rready, ch_start, ch_stop} !== 6'b0)
      begin bad++; $display("FAIL reset_ctl: got %b want 000000", {busy, done, m_axi_arvalid, m_axi_rready, ch_start, ch_stop}); end
    total++;
    if ({result, csw_status, csw_count} !== 27'b0)
      begin bad++; $display("FAIL reset_csw: got %h want 0", {result, csw_status, csw_count}); end
    total++;
    if ({csw_ccw_addr, m_axi_araddr} !== 64'b0)
      begin bad++; $display("FAIL reset_addr: got %h want 0", {csw_ccw_addr, m_axi_araddr}); end
    total++;
    if ({ch_command, ch_count, ch_data_addr} !== 56'b0)
      begin bad++; $display("FAIL reset_ch: got %h want 0", {ch_command, ch_count, ch_data_addr}); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_single;
    mem[32'h100] = mk(8'h01, 24'h001000, 1'b0, 1'b0, 16'd5);
    ch_len = 10; ch_stat = 8'h0C; ch_resid = 16'd0;
    exp_fetch.push_back(32'h100);
    exp_chs.push_back({8'h01, 16'd5, 32'h1000});
    push_done(3'd0, 32'h108, 8'h0C, 16'd0, 1'b1);
    run_prog(32'h100);
    wait_done("single", 200);
    check_empty("single");
  endtask

  task automatic test_chain_skip;
    mem[32'h100] = mk(8'h02, 24'h002000, 1'b0, 1'b1, 16'd4);
    mem[32'h108] = mk(8'h77, 24'h007000, 1'b0, 1'b0, 16'd1);
    mem[32'h110] = mk(8'h03, 24'h003000, 1'b0, 1'b0, 16'd6);
    ch_stat = 8'h4C; ch_resid = 16'd3;
    exp_fetch.push_back(32'h100);
    exp_fetch.push_back(32'h110);
    exp_chs.push_back({8'h02, 16'd4, 32'h2000});
    exp_chs.push_back({8'h03, 16'd6, 32'h3000});
    push_done(3'd0, 32'h118, 8'h4C, 16'd3, 1'b1);
    run_prog(32'h100);
    wait_done("chain", 300);
    check_empty("chain");
  endtask

  task automatic test_tic;
    mem[32'h100] = mk(8'h08, 24'h000200, 1'b0, 1'b0, 16'd0);
    mem[32'h200] = mk(8'h01, 24'h004000, 1'b0, 1'b0, 16'd7);
    ch_stat = 8'h0C; ch_resid = 16'd0;
    exp_fetch.push_back(32'h100);
    exp_fetch.push_back(32'h200);
    exp_chs.push_back({8'h01, 16'd7, 32'h4000});
    push_done(3'd0, 32'h208, 8'h0C, 16'd0, 1'b1);
    run_prog(32'h100);
    wait_done("tic", 200);
    check_empty("tic");
    // TIC followed by TIC is a program check
    mem[32'h100] = mk(8'h08, 24'h000200, 1'b0, 1'b0, 16'd0);
    mem[32'h200] = mk(8'h08, 24'h000300, 1'b0, 1'b0, 16'd0);
    exp_fetch.push_back(32'h100);
    exp_fetch.push_back(32'h200);
    push_done(3'd2, 32'h208, 8'h00, 16'd0, 1'b0);
    run_prog(32'h100);
    wait_done("tic_tic", 200);
    check_empty("tic_tic");
  endtask

  task automatic test_timeout;
    ch_never = 1'b1;
    mem[32'h100] = mk(8'h04, 24'h005000, 1'b0, 1'b0, 16'd9);
    exp_fetch.push_back(32'h100);
    exp_chs.push_back({8'h04, 16'd9, 32'h5000});
    push_done(3'd4, 32'h108, 8'h00, 16'd0, 1'b0);
    run_prog(32'h100);
    wait_done("timeout", 200);
    total++;
    if (done_cyc - chs_cyc != 16) begin bad++; $display("FAIL timeout_latency: got %0d want 16", done_cyc - chs_cyc); end
    ch_never = 1'b0;
    check_empty("timeout");
  endtask

  task automatic test_unit_check;
    mem[32'h100] = mk(8'h01, 24'h001000, 1'b0, 1'b0, 16'd5);
    ch_stat = 8'h0E; ch_resid = 16'd2;
    exp_fetch.push_back(32'h100);
    exp_chs.push_back({8'h01, 16'd5, 32'h1000});
    push_done(3'd1, 32'h108, 8'h0E, 16'd2, 1'b1);
    run_prog(32'h100);
    wait_done("unit", 200);
    check_empty("unit");
  endtask

  task automatic test_axi_err;
    err_addr = 32'h100;
    mem[32'h100] = mk(8'h01, 24'h001000, 1'b0, 1'b0, 16'd5);
    exp_fetch.push_back(32'h100);
    push_done(3'd3, 32'h108, 8'h00, 16'd0, 1'b0);
    run_prog(32'h100);
    wait_done("axi_err", 100);
    err_addr = 32'hFFFF_FFF8;
    check_empty("axi_err");
  endtask

  task automatic test_misaligned;
    // no fetch happens, so the CSW address still reflects the prior program
    push_done(3'd2, 32'h108, 8'h00, 16'd0, 1'b0);
    run_prog(32'h104);
    wait_done("misaligned", 20);
    check_empty("misaligned");
  endtask

  task automatic test_stop_run;
    int n0;
    mem[32'h100] = mk(8'h01, 24'h001000, 1'b0, 1'b0, 16'd5);
    ch_len = 40; ch_stat = 8'h0C; ch_resid = 16'h0033;
    exp_fetch.push_back(32'h100);
    exp_chs.push_back({8'h01, 16'd5, 32'h1000});
    push_done(3'd5, 32'h108, 8'h00, 16'h0033, 1'b1);
    run_prog(32'h100);
    wait_active("stop");
    tick(3);
    n0 = chstop_n;
    stop = 1'b1;
    wait_done("stop", 100);
    stop = 1'b0;
    total++;
    if (chstop_n - n0 != 1) begin bad++; $display("FAIL stop_pulses: got %0d want 1", chstop_n - n0); end
    ch_len = 10;
    check_empty("stop");
  endtask

  task automatic test_reset_mid;
    int k, n0;
    r_delay = 6;
    mem[32'h100] = mk(8'h01, 24'h001000, 1'b0, 1'b0, 16'd5);
    exp_fetch.push_back(32'h100);
    run_prog(32'h100);
    k = 0;
    while (!m_axi_rready && k < 20) begin tick(1); k++; end
    total++;
    if (!m_axi_rready) begin bad++; $display("FAIL rst_mid_fetch_r: got 0 want 1"); end
    n0 = done_n;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, m_axi_arvalid, m_axi_rready, ch_start, ch_stop} !== 6'b0)
      begin bad++; $display("FAIL rst_mid_ctl: got %b want 000000", {busy, done, m_axi_arvalid, m_axi_rready, ch_start, ch_stop}); end
    total++;
    if ({result, csw_ccw_addr, csw_count, m_axi_araddr} !== 83'b0)
      begin bad++; $display("FAIL rst_mid_csw: got %h want 0", {result, csw_ccw_addr, csw_count, m_axi_araddr}); end
    total++;
    if ({ch_command, ch_count, ch_data_addr} !== 56'b0)
      begin bad++; $display("FAIL rst_mid_ch: got %h want 0", {ch_command, ch_count, ch_data_addr}); end
    tick(2);
    reset = 1'b0;
    tick(12);
    total++;
    if (done_n != n0) begin bad++; $display("FAIL rst_mid_done: got %0d want 0", done_n - n0); end
    r_delay = 0;
    check_empty("rst_mid");
  endtask

  task automatic test_back_to_back;
    mem[32'h100] = mk(8'h01, 24'h001000, 1'b0, 1'b0, 16'd5);
    mem[32'h300] = mk(8'h02, 24'h002000, 1'b0, 1'b0, 16'd3);
    ch_stat = 8'h0C; ch_resid = 16'd0;
    exp_fetch.push_back(32'h100);
    exp_chs.push_back({8'h01, 16'd5, 32'h1000});
    push_done(3'd0, 32'h108, 8'h0C, 16'd0, 1'b1);
    run_prog(32'h100);
    wait_active("b2b");
    run_prog(32'h300);   // busy: must be ignored
    wait_done("b2b_first", 200);
    exp_fetch.push_back(32'h300);
    exp_chs.push_back({8'h02, 16'd3, 32'h2000});
    push_done(3'd0, 32'h308, 8'h0C, 16'd0, 1'b1);
    run_prog(32'h300);
    wait_done("b2b_second", 200);
    check_empty("b2b");
  endtask

  initial begin
    test_reset();
    test_single();
    test_chain_skip();
    test_tic();
    test_timeout();
    test_unit_check();
    test_axi_err();
    test_misaligned();
    test_stop_run();
    test_reset_mid();
    test_back_to_back();
    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccw_chain_sequencer.md
Name: ccw_chain_sequencer

Overview:
- Channel program controller in front of the channel engine and its DMA path.
- On start, fetches 64-bit CCWs from memory over an AXI4-Lite-style read master.
- Loads each CCW into the channel's command/count/data-address inputs, pulses channel start, and waits for the channel to go idle.
- Follows command chaining, TIC and status-modifier skip, then reports a CSW-style result: CCW address, residual count, device status, completion code.

Parameters:
- START_TIMEOUT, 1024, cycles allowed between ch_start and first observed ch_active before aborting.
- MAX_CHAIN, 255, maximum CCWs executed per program; exceeding it is a program check.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begin program at caw_addr; ignored while busy
- stop  in  1  level; abort the current program
- caw_addr  in  32  address of first CCW
- busy  out  1  program in progress
- done  out  1  one-cycle pulse at program end
- result  out  3  0 OK, 1 unit abnormal, 2 program check, 3 AXI error, 4 start timeout, 5 stopped
- csw_ccw_addr  out  32  address of last fetched CCW + 8
- csw_status  out  8  last device status byte
- csw_count  out  16  residual count from channel
- m_axi_araddr  out  32  CCW fetch address
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  64  CCW data
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready
- ch_command  out  8  CCW command to channel
- ch_count  out  16  CCW count
- ch_data_addr  out  32  CCW data address
- ch_start  out  1  one-cycle channel start pulse
- ch_stop  out  1  one-cycle channel stop pulse
- ch_active  in  1  channel busy
- ch_status_tdata  in  8  device status byte
- ch_status_tvalid  in  1  status byte valid
- ch_residual  in  16  channel remaining count, valid once ch_active falls

Behaviour:
- Reset:
  - All outputs are 0 and the FSM is in IDLE.
  - Reset asserted mid-program abandons the program immediately.
  - No done pulse is produced for the abandoned program, and any in-flight AXI beat is not waited for.
- CCW format (rdata):
  - [63:56] command.
  - [55:32] data address, zero-extended to 32 bits.
  - [31] CD, [30] CC, [29] SLI; other flag bits are ignored.
  - [15:0] count.
- States: IDLE, FETCH_AR, FETCH_R, DECODE, START, WAIT_ACTIVE, RUN, STOPPING, FINISH.
- IDLE:
  - start latches ptr=caw_addr, clears chain_cnt and the TIC flag, sets busy, and moves to FETCH_AR.
  - If caw_addr[2:0]!=0, go to FINISH with result 2 and no fetch.
- FETCH_AR:
  - araddr=ptr, arvalid=1 until the arready handshake, then FETCH_R.
  - arvalid never drops before the handshake.
- FETCH_R:
  - rready=1; on rvalid, capture the CCW and set csw_ccw_addr=ptr+8.
  - rresp!=0 goes to FINISH with result 3; otherwise DECODE.
- Stop during FETCH_AR/FETCH_R:
  - The outstanding handshake completes; the beat is discarded.
  - Then FINISH with result 5.
- DECODE (one cycle):
  - Command[3:0]==4'h8 (TIC): a second consecutive TIC, or a target with [2:0]!=0, gives result 2. Otherwise set ptr=data address, set the TIC flag, and go to FETCH_AR. chain_cnt is unchanged.
  - CD set, count==0, or chain_cnt==MAX_CHAIN gives result 2.
  - Otherwise drive ch_command/count/data_addr (held stable until the next DECODE), chain_cnt+=1, clear the TIC flag, go to START.
- START: ch_start=1 for exactly one cycle, clear the timeout counter, then WAIT_ACTIVE.
- WAIT_ACTIVE:
  - ch_active=1 goes to RUN.
  - Counter reaching START_TIMEOUT, or a ch_status_tvalid with status containing 0x02 unit check, gives result 4 or 1 respectively.
- ch_status_tvalid capture:
  - Captured into csw_status in any state.
  - If it coincides with the start pulse, the status wins over the clear.
  - csw_status is cleared at each START.
- RUN:
  - Wait for ch_active=0, then latch csw_count=ch_residual and evaluate status.
  - Status with bit 0x02 or 0x01 set, or without 0x08 CE and 0x04 DE, gives result 1.
  - Else CC=0 gives result 0.
  - Else CC=1 sets ptr+=8 (status 0x4C SM gives ptr+=16) and goes to FETCH_AR.
- Stop during START/WAIT_ACTIVE/RUN:
  - ch_stop pulses once, then STOPPING.
  - STOPPING waits for ch_active=0, latches csw_count, then result 5.
  - Stop takes priority over a same-cycle chain decision.
- FINISH: done=1 for one cycle with result valid; busy drops the same cycle; return to IDLE.
- Widths: ptr arithmetic is modulo 2^32 (wrap allowed). chain_cnt is 8 bits.
- start while busy: ignored, no side effect.

Test Plan:
- Single CCW 0x01 addr 0x1000 count 5 at caw 0x100; channel active 10 cycles, status 0x0C, residual 0 -> one ch_start with command 0x01, count 5, data_addr 0x1000; done, result 0, csw_ccw_addr 0x108, csw_status 0x0C, csw_count 0.
- Chain: CCW@0x100 CC=1, CCW@0x108 CC=0; first status 0x4C -> second fetch from 0x110 (skip); result 0, csw_ccw_addr 0x118.
- TIC@0x100 to 0x200, CCW@0x200 -> fetch order 0x100, 0x200. TIC@0x100 followed by TIC@0x200 -> result 2, no ch_start.
- ch_active never rises with START_TIMEOUT=16 -> done 16 cycles after ch_start, result 4. A status byte of 0x0E during RUN -> result 1, csw_status 0x0E.
- rresp=2'b10 on first fetch -> result 3, no ch_start. caw_addr 0x104 -> result 2, arvalid never asserted.
- stop asserted mid-RUN -> single ch_stop pulse; done after ch_active falls, result 5, csw_count=ch_residual. Reset asserted mid-FETCH_R -> all outputs 0 the same cycle.
